// File: rtl/tpu_host_sequencer_if.sv
// Bundle of the command, SRAM and accelerator signals of the host sequencer.
// The master modport is the sequencer's view. The slave modport is the view of
// the surrounding command block, SRAM and accelerator.
interface tpu_host_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int MODE_WIDTH = 4,
  parameter int PLEN_WIDTH = 8
);
  // command side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [MODE_WIDTH-1:0] cmd_mode;
  logic [ADDR_WIDTH-1:0] cmd_param_base;
  logic [PLEN_WIDTH-1:0] cmd_param_len;
  logic [ADDR_WIDTH-1:0] cmd_data_base;
  logic [ADDR_WIDTH-1:0] cmd_data_len;
  // SRAM read port
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // accelerator side
  logic                  acc_start;
  logic [MODE_WIDTH-1:0] acc_mode;
  logic                  acc_param_valid;
  logic [DATA_WIDTH-1:0] acc_param_data;
  logic                  acc_param_ready;
  logic                  acc_stream_valid;
  logic [DATA_WIDTH-1:0] acc_stream_data;
  logic                  acc_stream_ready;
  logic                  acc_done;
  // status
  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_mode, cmd_param_base, cmd_param_len, cmd_data_base, cmd_data_len,
    input  mem_rdata, acc_param_ready, acc_stream_ready, acc_done,
    output cmd_ready, mem_en, mem_addr, acc_start, acc_mode,
    output acc_param_valid, acc_param_data, acc_stream_valid, acc_stream_data, busy, done
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_param_base, cmd_param_len, cmd_data_base, cmd_data_len,
    output mem_rdata, acc_param_ready, acc_stream_ready, acc_done,
    input  cmd_ready, mem_en, mem_addr, acc_start, acc_mode,
    input  acc_param_valid, acc_param_data, acc_stream_valid, acc_stream_data, busy, done
  );
endinterface

// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer: accepts one command, streams the parameter block and then
// the data block from a 1-cycle-latency SRAM into the accelerator through a
// 2-entry FIFO, waits for the accelerator's done and pulses completion.
module tpu_host_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int MODE_WIDTH = 4,
  parameter int PLEN_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  tpu_host_sequencer_if.master bus
);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_PARAM  = 5'b00010,
    S_STREAM = 5'b00100,
    S_WAIT   = 5'b01000,
    S_FIN    = 5'b10000
  } state_t;

  state_t                state_r;
  state_t                state_next_s;

  // latched command
  logic [MODE_WIDTH-1:0] mode_r;
  logic [ADDR_WIDTH-1:0] param_base_r;
  logic [PLEN_WIDTH-1:0] param_len_r;
  logic [ADDR_WIDTH-1:0] data_base_r;
  logic [ADDR_WIDTH-1:0] data_len_r;
  logic                  acc_start_r;

  // fetch engine
  logic [ADDR_WIDTH-1:0] issued_cnt_r;
  logic [ADDR_WIDTH-1:0] accepted_cnt_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            fifo_cnt_r;

  logic                  in_fetch_s;
  logic [ADDR_WIDTH-1:0] cur_len_s;
  logic [ADDR_WIDTH-1:0] cur_base_s;
  logic                  param_valid_s;
  logic                  stream_valid_s;
  logic                  pop_s;
  logic [2:0]            occupancy_s;
  logic                  issue_s;
  logic                  phase_done_s;
  logic                  fetch_clear_s;
  logic [DATA_WIDTH-1:0] head_s;

  // Fetch-phase decode: current block, handshake and read-issue decision.
  always_comb begin
    in_fetch_s     = (state_r == S_PARAM) || (state_r == S_STREAM);
    if (state_r == S_PARAM) begin
      cur_len_s  = {{(ADDR_WIDTH-PLEN_WIDTH){1'b0}}, param_len_r};
      cur_base_s = param_base_r;
    end else begin
      cur_len_s  = data_len_r;
      cur_base_s = data_base_r;
    end
    head_s         = fifo_mem_r[rd_ptr_r];
    param_valid_s  = (state_r == S_PARAM)  && (fifo_cnt_r != 2'd0);
    stream_valid_s = (state_r == S_STREAM) && (fifo_cnt_r != 2'd0);
    pop_s          = (param_valid_s && bus.acc_param_ready) ||
                     (stream_valid_s && bus.acc_stream_ready);
    // words held or on their way; a pop this cycle frees one slot
    occupancy_s    = {1'b0, fifo_cnt_r} + {2'b00, inflight_r};
    issue_s        = in_fetch_s && (issued_cnt_r < cur_len_s) &&
                     (occupancy_s < (3'd2 + {2'b00, pop_s}));
    phase_done_s   = in_fetch_s && (accepted_cnt_r == cur_len_s);
    fetch_clear_s  = (state_r == S_IDLE) || phase_done_s;
  end

  // Next-state selection for the one-hot sequencer FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!bus.cmd_valid) begin
          state_next_s = S_IDLE;
        end else if (bus.cmd_param_len != {PLEN_WIDTH{1'b0}}) begin
          state_next_s = S_PARAM;
        end else if (bus.cmd_data_len != {ADDR_WIDTH{1'b0}}) begin
          state_next_s = S_STREAM;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_PARAM: begin
        if (!phase_done_s) begin
          state_next_s = S_PARAM;
        end else if (data_len_r != {ADDR_WIDTH{1'b0}}) begin
          state_next_s = S_STREAM;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_STREAM: begin
        if (phase_done_s) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_STREAM;
        end
      end
      S_WAIT: begin
        if (bus.acc_done) begin
          state_next_s = S_FIN;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_FIN:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the command on acceptance and generate the one-cycle start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r       <= {MODE_WIDTH{1'b0}};
      param_base_r <= {ADDR_WIDTH{1'b0}};
      param_len_r  <= {PLEN_WIDTH{1'b0}};
      data_base_r  <= {ADDR_WIDTH{1'b0}};
      data_len_r   <= {ADDR_WIDTH{1'b0}};
      acc_start_r  <= 1'b0;
    end else begin
      acc_start_r <= (state_r == S_IDLE) && bus.cmd_valid;
      if ((state_r == S_IDLE) && bus.cmd_valid) begin
        mode_r       <= bus.cmd_mode;
        param_base_r <= bus.cmd_param_base;
        param_len_r  <= bus.cmd_param_len;
        data_base_r  <= bus.cmd_data_base;
        data_len_r   <= bus.cmd_data_len;
      end
    end
  end

  // Read counters, in-flight flag and 2-entry FIFO; cleared between phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt_r   <= {ADDR_WIDTH{1'b0}};
      accepted_cnt_r <= {ADDR_WIDTH{1'b0}};
      inflight_r     <= 1'b0;
      fifo_mem_r[0]  <= {DATA_WIDTH{1'b0}};
      fifo_mem_r[1]  <= {DATA_WIDTH{1'b0}};
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      fifo_cnt_r     <= 2'd0;
    end else if (fetch_clear_s) begin
      issued_cnt_r   <= {ADDR_WIDTH{1'b0}};
      accepted_cnt_r <= {ADDR_WIDTH{1'b0}};
      inflight_r     <= 1'b0;
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      fifo_cnt_r     <= 2'd0;
    end else begin
      if (issue_s) begin
        issued_cnt_r <= issued_cnt_r + ADDR_WIDTH'(1);
      end
      if (pop_s) begin
        accepted_cnt_r <= accepted_cnt_r + ADDR_WIDTH'(1);
        rd_ptr_r       <= ~rd_ptr_r;
      end
      // SRAM data lands one cycle after the read was issued
      inflight_r <= issue_s;
      if (inflight_r) begin
        fifo_mem_r[wr_ptr_r] <= bus.mem_rdata;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

  // Output drive: status decoded from the state register.
  assign bus.cmd_ready        = (state_r == S_IDLE);
  assign bus.busy             = (state_r != S_IDLE);
  assign bus.done             = (state_r == S_FIN);
  assign bus.acc_start        = acc_start_r;
  assign bus.acc_mode         = mode_r;
  assign bus.mem_en           = issue_s;
  assign bus.mem_addr         = cur_base_s + issued_cnt_r;
  assign bus.acc_param_valid  = param_valid_s;
  assign bus.acc_stream_valid = stream_valid_s;
  assign bus.acc_param_data   = (state_r == S_PARAM)  ? head_s : {DATA_WIDTH{1'b0}};
  assign bus.acc_stream_data  = (state_r == S_STREAM) ? head_s : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Self-checking bench for tpu_host_sequencer: an SRAM model, expected-word and
// expected-address scoreboards filled when a command is issued and drained at
// every handshake / read seen on the bus.
module tb_tpu_host_sequencer;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int MW = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_host_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE_WIDTH(MW), .PLEN_WIDTH(PW)) bus_if ();

  tpu_host_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MODE_WIDTH(MW), .PLEN_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_param_q [$];
  logic [DW-1:0] exp_stream_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [MW-1:0] exp_mode = 4'h0;

  int  cyc = 0;
  int  mem_en_cnt = 0;
  int  start_cnt = 0;
  int  done_cnt = 0;
  int  pvalid_cyc = 0;
  int  s_first = -1;
  int  s_last = -1;
  bit  bp_en = 1'b0;
  bit  hold_pending = 1'b0;
  logic [DW-1:0] hold_data = 16'h0000;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC35A ^ {12'h000, a[19:16]};
  endfunction

  // synchronous SRAM model, one-cycle read latency
  always @(posedge clk) begin
    if (bus_if.mem_en) bus_if.mem_rdata <= sram_word(bus_if.mem_addr);
  end

  // ready driver, randomised when backpressure is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus_if.acc_stream_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.acc_param_ready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // bus monitor on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_if.mem_en) begin
        mem_en_cnt++;
        if (exp_addr_q.size() == 0) check_value("mem_extra_read", 32'd1, 32'd0);
        else check_value("mem_addr", bus_if.mem_addr, exp_addr_q.pop_front());
      end
      if (bus_if.acc_start) begin
        start_cnt++;
        check_value("acc_mode", bus_if.acc_mode, exp_mode);
      end
      if (bus_if.done) done_cnt++;
      if (bus_if.acc_param_valid) pvalid_cyc++;
      if (bus_if.acc_param_valid && bus_if.acc_param_ready) begin
        if (exp_param_q.size() == 0) check_value("param_extra", 32'd1, 32'd0);
        else check_value("param_word", bus_if.acc_param_data, exp_param_q.pop_front());
      end
      if (hold_pending && rst_n) begin
        check_value("stream_hold_valid", bus_if.acc_stream_valid, 32'd1);
        check_value("stream_hold_data", bus_if.acc_stream_data, hold_data);
      end
      if (bus_if.acc_stream_valid && bus_if.acc_stream_ready) begin
        if (s_first < 0) s_first = cyc;
        s_last = cyc;
        if (exp_stream_q.size() == 0) check_value("stream_extra", 32'd1, 32'd0);
        else check_value("stream_word", bus_if.acc_stream_data, exp_stream_q.pop_front());
      end
      hold_pending = rst_n && bus_if.acc_stream_valid && !bus_if.acc_stream_ready;
      hold_data    = bus_if.acc_stream_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_cmd_ready"}, bus_if.cmd_ready, 32'd1);
    check_value({tag, "_busy"}, bus_if.busy, 32'd0);
    check_value({tag, "_mem_en"}, bus_if.mem_en, 32'd0);
    check_value({tag, "_acc_start"}, bus_if.acc_start, 32'd0);
    check_value({tag, "_pvalid"}, bus_if.acc_param_valid, 32'd0);
    check_value({tag, "_svalid"}, bus_if.acc_stream_valid, 32'd0);
    check_value({tag, "_done"}, bus_if.done, 32'd0);
    check_value({tag, "_acc_mode"}, bus_if.acc_mode, 32'd0);
  endtask

  // push expectations and present a command for one accepting edge
  task automatic start_cmd(input logic [MW-1:0] mode, input logic [AW-1:0] pbase, input int plen,
                           input logic [AW-1:0] dbase, input int dlen, input bit keep_valid);
    logic [AW-1:0] a;
    for (int i = 0; i < plen; i++) begin
      a = pbase + AW'(i);
      exp_addr_q.push_back(a);
      exp_param_q.push_back(sram_word(a));
    end
    for (int i = 0; i < dlen; i++) begin
      a = dbase + AW'(i);
      exp_addr_q.push_back(a);
      exp_stream_q.push_back(sram_word(a));
    end
    exp_mode = mode;
    s_first = -1;
    s_last = -1;
    bus_if.cmd_mode       = mode;
    bus_if.cmd_param_base = pbase;
    bus_if.cmd_param_len  = PW'(plen);
    bus_if.cmd_data_base  = dbase;
    bus_if.cmd_data_len   = AW'(dlen);
    bus_if.cmd_valid      = 1'b1;
    tick();
    if (keep_valid) begin
      // a different command held while busy must be ignored
      bus_if.cmd_mode      = ~mode;
      bus_if.cmd_param_len = 8'd1;
      bus_if.cmd_data_len  = 20'd1;
    end else begin
      bus_if.cmd_valid = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [MW-1:0] mode, input logic [AW-1:0] pbase, input int plen,
                         input logic [AW-1:0] dbase, input int dlen,
                         input bit bp, input bit spurious, input bit overlap);
    int s0, d0, m0, p0, k;
    bit sp_sent;
    s0 = start_cnt; d0 = done_cnt; m0 = mem_en_cnt; p0 = pvalid_cyc;
    sp_sent = 1'b0;
    bp_en = bp;
    start_cmd(mode, pbase, plen, dbase, dlen, overlap);
    k = 0;
    while ((exp_param_q.size() != 0 || exp_stream_q.size() != 0) && k < 3000) begin
      if (k == 4) bus_if.cmd_valid = 1'b0;
      if (spurious && !sp_sent && exp_stream_q.size() <= dlen - 2) begin
        bus_if.acc_done = 1'b1;
        sp_sent = 1'b1;
      end else begin
        bus_if.acc_done = 1'b0;
      end
      tick();
      k++;
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.acc_done  = 1'b0;
    bp_en = 1'b0;
    if (k >= 3000) check_value("drain_timeout", 32'd0, 32'd1);
    repeat (5) tick();
    check_value("no_early_done", done_cnt - d0, 32'd0);
    check_value("busy_in_wait", bus_if.busy, 32'd1);
    bus_if.acc_done = 1'b1;
    tick();
    bus_if.acc_done = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) check_value("done_timeout", 32'd0, 32'd1);
    check_value("idle_cmd_ready", bus_if.cmd_ready, 32'd1);
    check_value("idle_busy", bus_if.busy, 32'd0);
    check_value("start_count", start_cnt - s0, 32'd1);
    check_value("done_count", done_cnt - d0, 32'd1);
    check_value("mem_en_count", mem_en_cnt - m0, plen + dlen);
    check_value("addr_left", exp_addr_q.size(), 32'd0);
    if (plen == 0) check_value("no_param_valid", pvalid_cyc - p0, 32'd0);
    if (!bp && dlen > 1) check_value("stream_span", s_last - s_first, dlen - 1);
  endtask

  initial begin
    int k, d0, m0;
    bus_if.cmd_valid        = 1'b0;
    bus_if.cmd_mode         = 4'h0;
    bus_if.cmd_param_base   = 20'h00000;
    bus_if.cmd_param_len    = 8'd0;
    bus_if.cmd_data_base    = 20'h00000;
    bus_if.cmd_data_len     = 20'd0;
    bus_if.acc_param_ready  = 1'b1;
    bus_if.acc_stream_ready = 1'b1;
    bus_if.acc_done         = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_cmd(4'h3, 20'h00100, 3, 20'h00200, 8, 1'b0, 1'b0, 1'b0);   // basic
    run_cmd(4'h5, 20'h00300, 3, 20'h00400, 16, 1'b1, 1'b0, 1'b0);  // backpressure
    run_cmd(4'h1, 20'h00000, 0, 20'h00500, 4, 1'b0, 1'b0, 1'b0);   // no params
    run_cmd(4'h2, 20'h00000, 0, 20'h00000, 0, 1'b0, 1'b0, 1'b0);   // both empty
    run_cmd(4'h7, 20'hFFFFF, 2, 20'hFFFFE, 4, 1'b0, 1'b0, 1'b0);   // address wrap
    run_cmd(4'h9, 20'h00600, 3, 20'h00700, 8, 1'b0, 1'b1, 1'b1);   // spurious done, overlap

    // reset in the middle of the stream phase
    start_cmd(4'h6, 20'h00800, 2, 20'h00900, 8, 1'b0);
    k = 0;
    while (exp_stream_q.size() > 6 && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check_value("midrst_timeout", 32'd0, 32'd1);
    d0 = done_cnt;
    m0 = mem_en_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_param_q.delete();
    exp_stream_q.delete();
    exp_addr_q.delete();
    repeat (3) tick();
    check_value("midrst_no_read", mem_en_cnt - m0, 32'd0);
    check_value("midrst_no_done", done_cnt - d0, 32'd0);
    rst_n = 1'b1;
    tick();
    check_value("midrst_cmd_ready", bus_if.cmd_ready, 32'd1);
    run_cmd(4'hA, 20'h00100, 3, 20'h00200, 8, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
